fpu_mul_result_buffer: RTL and testbench

- Sits directly downstream of the single-precision multiplier (Top_Mul).
- Top_Mul has fixed latency and no backpressure. This block tracks issued operations, captures each product's {Sz,Ez,Mz} and five exception flags when it emerges, and queues them in a small FIFO behind a valid/ready port.
- Issues credits upstream so the FIFO can never overflow.
- Accumulates sticky exception flags (fflags) for the FPU status register.

---
 rtl/fpu_mul_result_buffer.sv | 112 +++++++++++
 tb/tb_fpu_mul_result_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_result_buffer.sv
// Result buffer behind the fixed-latency single-precision multiplier: tracks in-flight
// issues with a valid shift register, captures products into a FWFT FIFO, and grants credits.
module fpu_mul_result_buffer #(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CW      = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic          Sz,
    input  logic [7:0]    Ez,
    input  logic [22:0]   Mz,
    input  logic          invalid_flagex,
    input  logic          overflow_flagex,
    input  logic          underflow_flagex,
    input  logic          inexact_flagex,
    input  logic          zero_flagex,
    output logic [31:0]   res_data,
    output logic [4:0]    res_flags,
    output logic          res_valid,
    input  logic          res_ready,
    input  logic          clr_flags,
    output logic [4:0]    fflags,
    output logic [CW-1:0] occupancy,
    output logic          err_ovf
);

    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [MUL_LAT-1:0] vld_q, vld_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [CW-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]      occ_q, occ_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [4:0]         fflags_q, fflags_d;
    logic               err_ovf_q, err_ovf_d;

    logic [31:0]        data_mem_q [DEPTH];
    logic [4:0]         flag_mem_q [DEPTH];

    logic               accept, capture, pop, push, full;
    logic [4:0]         flags_in;

    always_comb begin
        flags_in    = {invalid_flagex, overflow_flagex, underflow_flagex,
                       inexact_flagex, zero_flagex};
        // Credit depends only on registered counts, so a pop frees it one cycle later.
        issue_ready = occ_q < DEPTH_C;
        res_valid   = fifo_cnt_q != '0;
        accept      = issue_valid && issue_ready;
        capture     = vld_q[MUL_LAT-1];
        pop         = res_valid && res_ready;
        full        = fifo_cnt_q == DEPTH_C;
        push        = capture && (!full || pop);

        vld_d    = '0;
        vld_d[0] = accept;
        for (int unsigned i = 1; i < MUL_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end

        inflight_d = inflight_q + CW'(accept) - CW'(capture);
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        occ_d      = inflight_d + fifo_cnt_d;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        // A flag captured in the clear cycle survives the clear.
        fflags_d   = (clr_flags ? 5'b0 : fflags_q) | (capture ? flags_in : 5'b0);
        err_ovf_d  = err_ovf_q | (capture && full && !pop);

        res_data   = res_valid ? data_mem_q[rd_ptr_q] : '0;
        res_flags  = res_valid ? flag_mem_q[rd_ptr_q] : '0;
        fflags     = fflags_q;
        occupancy  = occ_q;
        err_ovf    = err_ovf_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_q      <= '0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fflags_q   <= '0;
            err_ovf_q  <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fflags_q   <= fflags_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the count is zero.
    always_ff @(posedge CLK) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= {Sz, Ez, Mz};
            flag_mem_q[wr_ptr_q] <= flags_in;
        end
    end

endmodule

// File: tb/tb_fpu_mul_result_buffer.sv
// Self-checking bench: emulates the multiplier as a delay line and checks the buffer
// against a queue-based model of in-flight and buffered results.
module tb_fpu_mul_result_buffer;

    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CW      = 5;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          issue_valid = 1'b0;
    logic          issue_ready;
    logic          Sz = 1'b0;
    logic [7:0]    Ez = '0;
    logic [22:0]   Mz = '0;
    logic          invalid_flagex = 1'b0, overflow_flagex = 1'b0, underflow_flagex = 1'b0;
    logic          inexact_flagex = 1'b0, zero_flagex = 1'b0;
    logic [31:0]   res_data;
    logic [4:0]    res_flags;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          clr_flags = 1'b0;
    logic [4:0]    fflags;
    logic [CW-1:0] occupancy;
    logic          err_ovf;

    always #5 CLK = ~CLK;

    fpu_mul_result_buffer #(.MUL_LAT(MUL_LAT), .DEPTH(DEPTH), .CW(CW)) dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .Sz(Sz), .Ez(Ez), .Mz(Mz),
        .invalid_flagex(invalid_flagex), .overflow_flagex(overflow_flagex),
        .underflow_flagex(underflow_flagex), .inexact_flagex(inexact_flagex),
        .zero_flagex(zero_flagex),
        .res_data(res_data), .res_flags(res_flags), .res_valid(res_valid),
        .res_ready(res_ready), .clr_flags(clr_flags), .fflags(fflags),
        .occupancy(occupancy), .err_ovf(err_ovf)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] d;
        logic [4:0]  f;
    } op_t;

    op_t         m_inf[$];
    op_t         m_fifo[$];
    logic [4:0]  m_fflags = '0;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] pipe_d [16];
    logic [4:0]  pipe_f [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        int unsigned sum;
        sum = m_inf.size() + m_fifo.size();
        check("res_valid", 32'(res_valid), 32'(m_fifo.size() != 0));
        check("res_data",  res_data,  (m_fifo.size() != 0) ? m_fifo[0].d : 32'h0);
        check("res_flags", 32'(res_flags), (m_fifo.size() != 0) ? 32'(m_fifo[0].f) : 32'h0);
        check("issue_ready", 32'(issue_ready), 32'(sum < DEPTH));
        check("occupancy", 32'(occupancy), sum);
        check("fflags",    32'(fflags), 32'(m_fflags));
        check("err_ovf",   32'(err_ovf), 32'h0);
    endtask

    // One clock cycle: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input logic iv, input logic [31:0] d, input logic [4:0] f,
                        input logic rr, input logic clr);
        logic pop, acc;
        op_t  e;
        issue_valid = iv;
        res_ready   = rr;
        clr_flags   = clr;
        pipe_d[(cyc + MUL_LAT) % 16] = iv ? d : $urandom;
        pipe_f[(cyc + MUL_LAT) % 16] = iv ? f : 5'($urandom);
        {Sz, Ez, Mz} = pipe_d[cyc % 16];
        {invalid_flagex, overflow_flagex, underflow_flagex, inexact_flagex, zero_flagex}
            = pipe_f[cyc % 16];
        pop = (m_fifo.size() != 0) && rr;
        acc = iv && ((m_inf.size() + m_fifo.size()) < DEPTH);
        @(posedge CLK);
        if (pop) e = m_fifo.pop_front();
        if (clr) m_fflags = '0;
        if (m_inf.size() != 0 && m_inf[0].due == cyc) begin
            e = m_inf.pop_front();
            m_fifo.push_back(e);
            m_fflags |= e.f;
        end
        if (acc) m_inf.push_back('{cyc + MUL_LAT, d, f});
        cyc++;
        #1;
        check_all();
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 32'h0, 5'h0, rr, 1'b0);
    endtask

    function automatic logic [31:0] i2f(input int unsigned k);
        int unsigned e;
        int unsigned m;
        e = 0;
        for (int unsigned i = 0; i < 24; i++) if ((k >> i) != 0) e = i;
        m = (k << (23 - e)) & 32'h7FFFFF;
        return {1'b0, 8'(e + 127), 23'(m)};
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin
            pipe_d[i] = '0;
            pipe_f[i] = '0;
        end
        repeat (10) @(posedge CLK);
        #1;
        check("rst_valid", 32'(res_valid), 32'h0);
        check("rst_data",  res_data, 32'h0);
        check("rst_flags", 32'(res_flags), 32'h0);
        check("rst_ready", 32'(issue_ready), 32'h1);
        check("rst_occ",   32'(occupancy), 32'h0);
        check("rst_fflags", 32'(fflags), 32'h0);
        check("rst_err",   32'(err_ovf), 32'h0);
        RST = 1'b1;

        // 2.0 * 3.0
        step(1'b1, 32'h40C00000, 5'b00000, 1'b0, 1'b0);
        repeat (MUL_LAT - 1) idle(1'b0);
        check("basic_lat", 32'(res_valid), 32'h0);
        idle(1'b0);
        check("basic_valid", 32'(res_valid), 32'h1);
        check("basic_data", res_data, 32'h40C00000);
        idle(1'b1);

        // 0x7F000000 * 0x7F000000 overflows
        step(1'b1, 32'h7F800000, 5'b01010, 1'b0, 1'b0);
        repeat (MUL_LAT) idle(1'b0);
        check("ovf_data", res_data, 32'h7F800000);
        check("ovf_flags", 32'(res_flags), 32'b01010);
        repeat (3) idle(1'b1);
        check("ovf_sticky", 32'(fflags), 32'b01010);
        step(1'b0, 32'h0, 5'h0, 1'b1, 1'b1);
        check("ovf_clr", 32'(fflags), 32'h0);

        // Backpressure until credits run out, then drain
        repeat (8) step(1'b1, $urandom, 5'($urandom), 1'b0, 1'b0);
        check("full_ready", 32'(issue_ready), 32'h0);
        check("full_occ", 32'(occupancy), DEPTH);
        repeat (8) idle(1'b1);

        // Back-to-back 1.0*k with consumer always ready
        for (int unsigned k = 1; k <= 20; k++) step(1'b1, i2f(k), 5'b00000, 1'b1, 1'b0);
        repeat (MUL_LAT + 2) idle(1'b1);

        // Clear racing a capture
        step(1'b1, 32'hFFC00000, 5'b10000, 1'b1, 1'b0);
        repeat (MUL_LAT + 1) idle(1'b1);
        step(1'b1, 32'h00000000, 5'b00110, 1'b1, 1'b0);
        repeat (MUL_LAT - 1) idle(1'b1);
        step(1'b0, 32'h0, 5'h0, 1'b1, 1'b1);
        check("race_fflags", 32'(fflags), 32'b00110);
        repeat (2) idle(1'b1);

        // Random traffic
        repeat (400) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        repeat (10) idle(1'b1);

        // Async reset with two queued and two in flight
        repeat (4) step(1'b1, $urandom, 5'($urandom), 1'b0, 1'b0);
        check("pre_rst_occ", 32'(occupancy), 32'd4);
        #2;
        RST = 1'b0;
        issue_valid = 1'b0;
        #1;
        check("arst_valid", 32'(res_valid), 32'h0);
        check("arst_occ", 32'(occupancy), 32'h0);
        check("arst_fflags", 32'(fflags), 32'h0);
        check("arst_data", res_data, 32'h0);
        m_inf.delete();
        m_fifo.delete();
        m_fflags = '0;
        repeat (3) @(posedge CLK);
        cyc += 3;
        #1;
        RST = 1'b1;
        check_all();
        repeat (MUL_LAT + 4) idle(1'b1);
        step(1'b1, 32'h3F800000, 5'b00000, 1'b1, 1'b0);
        repeat (MUL_LAT + 2) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
